// File: rtl/neuron_pkg.sv
// Shared types and constant helpers for the sequential MAC neuron.
package neuron_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StAct,
    StOut
  } state_e;

  // Bits needed to index v distinct values (0 for v <= 1).
  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

endpackage

// File: rtl/neuron_act.sv
// Rescale, round, saturate and activate the accumulator.
// NEURON_LEAKY_EN selects a leaky negative slope instead of plain ReLU.
module neuron_act
  import neuron_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 19,
  parameter int SHIFT = 6
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [DW-1:0]    y
);

  localparam int RW = ACC_W - SHIFT + 1;
  localparam int CW = (RW > DW) ? RW : DW;

  logic [CW-1:0]    r;
  logic             sat;
  logic [DW-1:0]    pos_y;

  // Rounding increment is added before the saturation check.
  always_comb begin
    r     = CW'(acc[ACC_W-1:SHIFT]) + CW'(acc[SHIFT-1]);
    sat   = (r > CW'(sat_max(DW)));
    pos_y = sat ? DW'(sat_max(DW)) : r[DW-1:0];
  end

`ifdef NEURON_LEAKY_EN
  logic signed [ACC_W-1:0] lk;
  logic signed [ACC_W-1:0] lk_min;

  always_comb begin
    lk     = acc >>> (SHIFT + 3);
    lk_min = $signed(ACC_W'(sat_min(DW)));
    if (!acc[ACC_W-1]) begin
      y = $signed(pos_y);
    end else if (lk < lk_min) begin
      y = $signed(DW'(sat_min(DW)));
    end else begin
      y = lk[DW-1:0];
    end
  end
`else
  always_comb begin
    y = acc[ACC_W-1] ? '0 : $signed(pos_y);
  end
`endif

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential single-multiplier neuron: bias + sum(act*w), then rescale/activate.
// Build option NEURON_LEAKY_EN is handled inside neuron_act.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int N_IN  = 5,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int SHIFT = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*DW-1:0]     act_flat,
  input  logic [N_IN*WW-1:0]     w_flat,
  input  logic [DW+WW-1:0]       bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data
);

  localparam int ACC_W = DW + WW + clog2(N_IN + 1);
  localparam int IDX_W = (clog2(N_IN) > 0) ? clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

  state_e                  state_q, state_d;
  logic [N_IN*DW-1:0]      act_q, act_d;
  logic [N_IN*WW-1:0]      w_q, w_d;
  logic [DW+WW-1:0]        bias_q, bias_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    out_valid_q, out_valid_d;
  logic [DW-1:0]           out_data_q, out_data_d;

  logic signed [DW-1:0]    act_sel;
  logic signed [WW-1:0]    w_sel;
  logic signed [DW+WW-1:0] prod;
  logic signed [DW-1:0]    act_y;

  // The only multiplier: operands are muxed by idx.
  always_comb begin
    act_sel = act_q[idx_q*DW +: DW];
    w_sel   = w_q[idx_q*WW +: WW];
    prod    = act_sel * w_sel;
  end

  neuron_act #(
    .DW    (DW),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_act (
    .acc (acc_q),
    .y   (act_y)
  );

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    w_d         = w_q;
    bias_d      = bias_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          act_d   = act_flat;
          w_d     = w_flat;
          bias_d  = bias;
          acc_d   = ACC_W'($signed(bias));
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + ACC_W'(prod);
        if (idx_q == IDX_LAST) begin
          state_d = StAct;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StAct: begin
        out_data_d  = act_y;
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      act_q       <= '0;
      w_q         <= '0;
      bias_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      w_q         <= w_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: directed table, corner sequences, random vs model.
module tb_neuron_mac_seq;

  localparam int N_IN  = 5;
  localparam int DW    = 8;
  localparam int WW    = 8;
  localparam int SHIFT = 6;
  localparam int LAT   = N_IN + 1;

`ifdef NEURON_LEAKY_EN
  localparam int NEG5_EXP = -4;
`else
  localparam int NEG5_EXP = 0;
`endif

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [N_IN*DW-1:0] act_flat;
  logic [N_IN*WW-1:0] w_flat;
  logic [DW+WW-1:0]   bias;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;

  neuron_mac_seq #(
    .N_IN  (N_IN),
    .DW    (DW),
    .WW    (WW),
    .SHIFT (SHIFT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act_flat  (act_flat),
    .w_flat    (w_flat),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int act_v[N_IN];
  int w_v[N_IN];
  int bias_v;

  typedef struct {
    int act;
    int exp_out;
  } vec_t;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < N_IN; i++) begin
      act_flat[i*DW +: DW] = DW'(act_v[i]);
      w_flat[i*WW +: WW]   = WW'(w_v[i]);
    end
    bias = (DW+WW)'(bias_v);
  endtask

  task automatic set_all_act(input int a);
    for (int i = 0; i < N_IN; i++) act_v[i] = a;
  endtask

  task automatic set_ref_w();
    w_v[0] = 19; w_v[1] = 31; w_v[2] = 31; w_v[3] = 8; w_v[4] = 31;
    bias_v = -1024;
  endtask

  // Behavioural reference: plain integer arithmetic from the neuron's rules.
  function automatic int ref_out();
    longint acc, r, q, d;
    acc = bias_v;
    for (int i = 0; i < N_IN; i++) acc += longint'(act_v[i]) * longint'(w_v[i]);
    if (acc >= 0) begin
      r = acc / (longint'(1) << SHIFT);
      if ((acc % (longint'(1) << SHIFT)) >= (longint'(1) << (SHIFT - 1))) r++;
      if (r > 127) r = 127;
      return int'(r);
    end
`ifdef NEURON_LEAKY_EN
    d = longint'(1) << (SHIFT + 3);
    q = acc / d;
    if (q * d != acc) q--;
    if (q < -128) q = -128;
    return int'(q);
`else
    d = 0;
    q = 0;
    return int'(q + d);
`endif
  endfunction

  // Presents the vector, waits for acceptance and for out_valid; does not consume.
  task automatic run_vec(output int data, output int lat);
    int n;
    pack();
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    // Scramble inputs after acceptance; the latched copy must be used.
    for (int i = 0; i < N_IN; i++) begin
      act_flat[i*DW +: DW] = DW'($urandom());
      w_flat[i*WW +: WW]   = WW'($urandom());
    end
    bias = (DW+WW)'($urandom());
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) check("result_timeout", 0, 1);
    data = int'($signed(out_data));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[3];
    int   data, lat, seen;
    int   seq_act[4];
    int   seq_exp[4];
    int   res_cyc[4];
    int   res_dat[4];
    int   nres, nxt, cyc;
    bit   accepting;

    tbl[0] = '{act: 10,  exp_out: 3};
    tbl[1] = '{act: 127, exp_out: 127};
    tbl[2] = '{act: -5,  exp_out: NEG5_EXP};

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    act_flat  = '0;
    w_flat    = '0;
    bias      = '0;
    set_ref_w();
    set_all_act(0);
    do_reset();

    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_in_ready", int'(in_ready), 1);

    // Directed reference vectors.
    for (int t = 0; t < 3; t++) begin
      set_ref_w();
      set_all_act(tbl[t].act);
      run_vec(data, lat);
      check($sformatf("tbl%0d_out", t), data, tbl[t].exp_out);
      check($sformatf("tbl%0d_latency", t), lat, LAT);
      check($sformatf("tbl%0d_in_ready_busy", t), int'(in_ready), 0);
      consume();
      check($sformatf("tbl%0d_consumed", t), int'(out_valid), 0);
      check($sformatf("tbl%0d_in_ready_after", t), int'(in_ready), 1);
    end

    // Output stall: result held, new input ignored.
    set_ref_w();
    set_all_act(10);
    run_vec(data, lat);
    check("stall_first_out", data, 3);
    set_all_act(127);
    pack();
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_data", int'($signed(out_data)), 3);
      check("stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    consume();
    check("stall_consumed", int'(out_valid), 0);
    check("stall_in_ready_after", int'(in_ready), 1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("stall_no_extra_result", seen, 0);

    // Reset in the third MAC cycle aborts the computation.
    set_ref_w();
    set_all_act(10);
    pack();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("midrst_no_result", seen, 0);
    set_all_act(10);
    run_vec(data, lat);
    check("midrst_next_out", data, 3);
    check("midrst_next_latency", lat, LAT);
    consume();

    // Back-to-back: in_valid and out_ready held high; N_IN+2 idle cycles between results.
    seq_act[0] = 10;  seq_exp[0] = 3;
    seq_act[1] = 127; seq_exp[1] = 127;
    seq_act[2] = 10;  seq_exp[2] = 3;
    seq_act[3] = 127; seq_exp[3] = 127;
    set_ref_w();
    nxt  = 0;
    nres = 0;
    cyc  = 0;
    set_all_act(seq_act[0]);
    pack();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (nres < 4 && cyc < 100) begin
      if (out_valid) begin
        res_cyc[nres] = cyc;
        res_dat[nres] = int'($signed(out_data));
        nres++;
      end
      accepting = in_ready;
      tick();
      cyc++;
      if (accepting) begin
        nxt++;
        set_all_act(seq_act[nxt % 4]);
        pack();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_result_count", nres, 4);
    for (int k = 0; k < nres; k++) begin
      check($sformatf("b2b_out%0d", k), res_dat[k], seq_exp[k]);
      if (k > 0) check($sformatf("b2b_spacing%0d", k), res_cyc[k] - res_cyc[k-1], N_IN + 3);
    end
    do_reset();

    // Random vectors against the reference model.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N_IN; i++) begin
        act_v[i] = int'($urandom_range(0, 255)) - 128;
        w_v[i]   = int'($urandom_range(0, 255)) - 128;
      end
      if (t % 2 == 0) bias_v = int'($urandom_range(0, 65535)) - 32768;
      else            bias_v = int'($urandom_range(0, 4095)) - 2048;
      run_vec(data, lat);
      check($sformatf("rand%0d_out", t), data, ref_out());
      check($sformatf("rand%0d_latency", t), lat, LAT);
      consume();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
